// File: rtl/zx_kbd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : zx_kbd_pkg
// Brief   : Decoder states, PS/2 prefix codes and the PS/2-to-ZX matrix map.
// Revision: 1.0
// ============================================================================
package zx_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXT    = 2'd1,
    BRK    = 2'd2,
    EXTBRK = 2'd3
  } dec_state_t;

  localparam logic [7:0] c_code_e0  = 8'hE0;
  localparam logic [7:0] c_code_f0  = 8'hF0;
  localparam logic [7:0] c_code_f1  = 8'h05;
  localparam logic [7:0] c_code_f11 = 8'h78;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  typedef struct packed {
    key_pos_t a;
    key_pos_t b;
  } key_pair_t;

  function automatic key_pos_t kp(input int unsigned r, input int unsigned c);
    key_pos_t p;
    p.valid = 1'b1;
    p.row   = 3'(r);
    p.col   = 3'(c);
    return p;
  endfunction

  // Slot b is only used by composite keys; slot a of those is always CapsShift.
  function automatic key_pair_t map_key(input logic [7:0] code, input logic ext);
    key_pair_t m;
    m = '0;
    if (ext) begin
      case (code)
        8'h6B:   begin m.a = kp(0, 0); m.b = kp(3, 4); end
        8'h72:   begin m.a = kp(0, 0); m.b = kp(4, 4); end
        8'h75:   begin m.a = kp(0, 0); m.b = kp(4, 3); end
        8'h74:   begin m.a = kp(0, 0); m.b = kp(4, 2); end
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: m.a = kp(0, 0);
        8'h1A: m.a = kp(0, 1);
        8'h22: m.a = kp(0, 2);
        8'h21: m.a = kp(0, 3);
        8'h2A: m.a = kp(0, 4);
        8'h1C: m.a = kp(1, 0);
        8'h1B: m.a = kp(1, 1);
        8'h23: m.a = kp(1, 2);
        8'h2B: m.a = kp(1, 3);
        8'h34: m.a = kp(1, 4);
        8'h15: m.a = kp(2, 0);
        8'h1D: m.a = kp(2, 1);
        8'h24: m.a = kp(2, 2);
        8'h2D: m.a = kp(2, 3);
        8'h2C: m.a = kp(2, 4);
        8'h16: m.a = kp(3, 0);
        8'h1E: m.a = kp(3, 1);
        8'h26: m.a = kp(3, 2);
        8'h25: m.a = kp(3, 3);
        8'h2E: m.a = kp(3, 4);
        8'h45: m.a = kp(4, 0);
        8'h46: m.a = kp(4, 1);
        8'h3E: m.a = kp(4, 2);
        8'h3D: m.a = kp(4, 3);
        8'h36: m.a = kp(4, 4);
        8'h4D: m.a = kp(5, 0);
        8'h44: m.a = kp(5, 1);
        8'h43: m.a = kp(5, 2);
        8'h3C: m.a = kp(5, 3);
        8'h35: m.a = kp(5, 4);
        8'h5A: m.a = kp(6, 0);
        8'h4B: m.a = kp(6, 1);
        8'h42: m.a = kp(6, 2);
        8'h3B: m.a = kp(6, 3);
        8'h33: m.a = kp(6, 4);
        8'h29: m.a = kp(7, 0);
        8'h14: m.a = kp(7, 1);
        8'h3A: m.a = kp(7, 2);
        8'h31: m.a = kp(7, 3);
        8'h32: m.a = kp(7, 4);
        8'h66:   begin m.a = kp(0, 0); m.b = kp(4, 0); end
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx
// Brief   : PS/2 receiver: sync, clock glitch filter, 11-bit frame, parity, timeout.
// Revision: 1.0
// ============================================================================
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 1400
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] c_filt_last = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] c_to_last   = TW'(TIMEOUT - 1);

  logic [1:0]    clk_s_q, dat_s_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic          byte_valid_q;
  logic          w_flip;
  logic          w_fall;
  logic          w_dat;

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample.
  assign w_flip = (clk_s_q[1] != filt_q) && (filt_cnt_q == c_filt_last);
  assign w_fall = w_flip && filt_q;
  assign w_dat  = dat_s_q[1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_s_q      <= 2'b11;
      dat_s_q      <= 2'b11;
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      clk_s_q      <= {clk_s_q[0], ps2_clk_i};
      dat_s_q      <= {dat_s_q[0], ps2_dat_i};
      byte_valid_q <= 1'b0;

      if (clk_s_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (w_flip) begin
        filt_q     <= clk_s_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end

      if (w_fall) begin
        to_cnt_q <= '0;
        case (bit_cnt_q)
          4'd0:  if (!w_dat) bit_cnt_q <= 4'd1;
          4'd9:  begin par_q <= w_dat; bit_cnt_q <= 4'd10; end
          4'd10: begin
            bit_cnt_q <= 4'd0;
            if (w_dat && (^shift_q ^ par_q)) byte_valid_q <= 1'b1;
          end
          default: begin
            shift_q   <= {w_dat, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        endcase
      end else if (bit_cnt_q != 4'd0) begin
        if (to_cnt_q == c_to_last) begin
          bit_cnt_q <= 4'd0;
          to_cnt_q  <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_q;

endmodule
`default_nettype wire

// File: rtl/ps2_zx_matrix.sv
`default_nettype none
// ============================================================================
// Module  : ps2_zx_matrix
// Brief   : PS/2 scancode decoder driving the ZX Spectrum 8x5 key matrix readout.
// Revision: 1.0
// ============================================================================
module ps2_zx_matrix
  import zx_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 1400
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  input  logic [15:0] A,
  output logic [4:0]  KEYB,
  output logic        F11,
  output logic        F1
);

  logic [7:0]       w_byte;
  logic             w_byte_valid;
  dec_state_t       state_q, state_d;
  logic             w_make, w_break, w_ext;
  key_pair_t        w_pair;
  logic [7:0][4:0]  key_q, key_d;
  logic             f1_q, f1_d, f11_q, f11_d;
  logic             w_unused;

  assign w_unused = ^A[7:0];

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk_i        (CLK),
    .rst_n_i      (nRESET),
    .ps2_clk_i    (PS2_CLK),
    .ps2_dat_i    (PS2_DAT),
    .byte_o       (w_byte),
    .byte_valid_o (w_byte_valid)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      key_q   <= '0;
      f1_q    <= 1'b0;
      f11_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      f1_q    <= f1_d;
      f11_q   <= f11_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_make  = 1'b0;
    w_break = 1'b0;
    w_ext   = 1'b0;
    if (w_byte_valid) begin
      case (state_q)
        IDLE: begin
          if (w_byte == c_code_e0)      state_d = EXT;
          else if (w_byte == c_code_f0) state_d = BRK;
          else begin
            case (w_byte)
              8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_make = 1'b0;
              default: w_make = 1'b1;
            endcase
          end
        end
        EXT: begin
          if (w_byte == c_code_f0) begin
            state_d = EXTBRK;
          end else begin
            state_d = IDLE;
            // E0 12 / E0 59 are shift states the keyboard fakes around nav keys.
            if (w_byte != 8'h12 && w_byte != 8'h59) begin
              w_make = 1'b1;
              w_ext  = 1'b1;
            end
          end
        end
        BRK: begin
          state_d = IDLE;
          w_break = 1'b1;
        end
        EXTBRK: begin
          state_d = IDLE;
          w_break = 1'b1;
          w_ext   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign w_pair = map_key(w_byte, w_ext);

  always_comb begin
    key_d = key_q;
    f1_d  = f1_q;
    f11_d = f11_q;
    if (w_make || w_break) begin
      if (w_pair.a.valid) key_d[w_pair.a.row][w_pair.a.col] = w_make;
      if (w_pair.b.valid) key_d[w_pair.b.row][w_pair.b.col] = w_make;
      if (!w_ext && w_byte == c_code_f1)  f1_d  = w_make;
      if (!w_ext && w_byte == c_code_f11) f11_d = w_make;
    end
  end

  always_comb begin
    KEYB = 5'b11111;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 5; c++) begin
        KEYB[c] = KEYB[c] & (A[8+r] | ~key_q[r][c]);
      end
    end
  end

  assign F1  = f1_q;
  assign F11 = f11_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_zx_matrix.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_zx_matrix
// Brief   : Directed PS/2 frames with a queued-expectation readout checker.
// Revision: 1.0
// ============================================================================
module tb_ps2_zx_matrix;

  logic        CLK     = 1'b0;
  logic        nRESET  = 1'b0;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DAT = 1'b1;
  logic [15:0] A       = 16'hFFFF;
  logic [4:0]  KEYB;
  logic        F11, F1;

  always #5 CLK = ~CLK;

  ps2_zx_matrix #(
    .FILTER_LEN (8),
    .TIMEOUT    (1400)
  ) dut (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .PS2_CLK (PS2_CLK),
    .PS2_DAT (PS2_DAT),
    .A       (A),
    .KEYB    (KEYB),
    .F11     (F11),
    .F1      (F1)
  );

  typedef struct {
    int         id;
    logic [15:0] addr;
    logic [6:0] exp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rd_id  = 0;
  logic rd_req = 1'b0;

  // Monitor: pops one expectation per read strobe, sampled on the falling edge.
  always @(negedge CLK) begin
    if (rd_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_underflow: no expectation queued at time %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({KEYB, F1, F11} !== mon_e.exp)
          begin
            errors++;
            $display("FAIL read%0d A=%h: KEYB/F1/F11 got %b/%b/%b want %b/%b/%b",
                     mon_e.id, mon_e.addr, KEYB, F1, F11,
                     mon_e.exp[6:2], mon_e.exp[1], mon_e.exp[0]);
          end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [4:0] k,
                    input logic f1 = 1'b0, input logic f11 = 1'b0);
    exp_t e;
    tick(1);
    A      = addr;
    e.id   = rd_id;
    e.addr = addr;
    e.exp  = {k, f1, f11};
    exp_q.push_back(e);
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
    rd_id++;
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    tick(10);
    PS2_CLK = 1'b0;
    tick(20);
    PS2_CLK = 1'b1;
    tick(10);
  endtask

  task automatic send(input logic [7:0] b, input logic badpar = 1'b0, input int nbits = 11);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    PS2_DAT = 1'b1;
    tick(20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tick(3);
    rd(16'h00FE, 5'b11111);
    nRESET = 1'b1;
    tick(5);
    rd(16'h00FE, 5'b11111);

    send(8'h1C);               rd(16'hFDFE, 5'b11110);
    send(8'hF0); send(8'h1C);  rd(16'hFDFE, 5'b11111);

    send(8'h12); send(8'h1A);
    rd(16'hFEFE, 5'b11100);
    rd(16'h00FE, 5'b11100);
    rd(16'hFDFE, 5'b11111);
    rd(16'hEFFE, 5'b11111);
    rd(16'h7FFE, 5'b11111);
    send(8'hF0); send(8'h1A); send(8'hF0); send(8'h12);
    rd(16'hFEFE, 5'b11111);

    send(8'h66);
    rd(16'hFEFE, 5'b11110);
    rd(16'hEFFE, 5'b11110);
    send(8'hF0); send(8'h66);
    rd(16'h00FE, 5'b11111);

    send(8'hAA); send(8'h14);  rd(16'h7FFE, 5'b11101);
    send(8'hF0); send(8'h14);  rd(16'h7FFE, 5'b11111);

    send(8'hE0); send(8'h75);
    rd(16'hFEFE, 5'b11110);
    rd(16'hEFFE, 5'b10111);
    send(8'hE0); send(8'hF0); send(8'h75);
    rd(16'hFEFE, 5'b11111);
    rd(16'hEFFE, 5'b11111);
    send(8'hE0); send(8'h12);  rd(16'hFEFE, 5'b11111);

    send(8'h1C, 1'b1);         rd(16'hFDFE, 5'b11111);
    send(8'h1C);               rd(16'hFDFE, 5'b11110);
    send(8'hF0); send(8'h1C);  rd(16'hFDFE, 5'b11111);

    send(8'h05, 1'b0, 5);
    tick(1410);
    send(8'h05);               rd(16'h00FE, 5'b11111, 1'b1, 1'b0);
    send(8'hF0); send(8'h05);  rd(16'h00FE, 5'b11111, 1'b0, 1'b0);
    send(8'h78);               rd(16'hFFFE, 5'b11111, 1'b0, 1'b1);
    send(8'hF0); send(8'h78);  rd(16'hFFFE, 5'b11111, 1'b0, 1'b0);

    send(8'h29);               rd(16'h7FFE, 5'b11110);
    send(8'h55, 1'b0, 4);
    nRESET = 1'b0;
    rd(16'h7FFE, 5'b11111);
    tick(1);
    nRESET = 1'b1;
    tick(5);
    rd(16'h7FFE, 5'b11111);
    send(8'h29);               rd(16'h7FFE, 5'b11110);

    // Short low pulses with data low would look like a start bit if accepted.
    PS2_DAT = 1'b0;
    for (int g = 0; g < 4; g++) begin
      PS2_CLK = 1'b0;
      tick(2);
      PS2_CLK = 1'b1;
      tick(15);
    end
    PS2_DAT = 1'b1;
    tick(10);
    send(8'hF0); send(8'h29);  rd(16'h7FFE, 5'b11111);

    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations not consumed, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
